// File: rtl/defines_pkg.sv
// Shared SPU definitions: opcode enum, issue-pipe classes and register field positions.
// pipe_of() maps an 11-bit opcode to the pipe class that can execute it.
package defines_pkg;

    localparam int unsigned OP_W   = 11;
    localparam int unsigned RT_LSB = 0;
    localparam int unsigned RA_LSB = 7;
    localparam int unsigned RB_LSB = 14;
    localparam int unsigned REG_W  = 7;

    typedef enum logic [OP_W-1:0] {
        STOP     = 11'h000,
        LNOP     = 11'h001,
        NOP      = 11'h201,
        // Fixed-point arithmetic and logical
        ADD_WORD = 11'h0C0,
        ADD_HALF = 11'h0C8,
        SF_WORD  = 11'h040,
        SF_HALF  = 11'h048,
        ADDX     = 11'h340,
        CG       = 11'h0C2,
        AND_W    = 11'h0C1,
        OR_W     = 11'h041,
        XOR_W    = 11'h241,
        NAND_W   = 11'h0C9,
        NOR_W    = 11'h049,
        ANDC     = 11'h2C1,
        ORC      = 11'h2C9,
        EQV      = 11'h249,
        CEQ      = 11'h3C0,
        CGT      = 11'h240,
        CLGT     = 11'h2C0,
        MPY      = 11'h3C4,
        MPYU     = 11'h3CC,
        // Single-precision floating point
        FA       = 11'h2C4,
        FS       = 11'h2C5,
        FM       = 11'h2C6,
        // Byte operations
        CNTB     = 11'h2B4,
        AVGB     = 11'h0D3,
        ABSDB    = 11'h053,
        SUMB     = 11'h253,
        // Shift and rotate
        SHL      = 11'h05B,
        SHLH     = 11'h05F,
        ROT      = 11'h058,
        ROTH     = 11'h05C,
        ROTM     = 11'h059
    } Opcodes;

    typedef enum logic [1:0] {PIPE_EVEN, PIPE_ODD, PIPE_CTRL, PIPE_ILLEGAL} pipe_e;

    function automatic pipe_e pipe_of(input logic [OP_W-1:0] op);
        pipe_e cls;
        case (op)
            ADD_WORD, ADD_HALF, SF_WORD, SF_HALF, ADDX, CG,
            AND_W, OR_W, XOR_W, NAND_W, NOR_W, ANDC, ORC, EQV,
            CEQ, CGT, CLGT, MPY, MPYU,
            FA, FS, FM,
            CNTB, AVGB, ABSDB, SUMB,
            SHL, SHLH, ROT, ROTH, ROTM,
            NOP:     cls = PIPE_EVEN;
            LNOP:    cls = PIPE_ODD;
            STOP:    cls = PIPE_CTRL;
            default: cls = PIPE_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/spu_issue_fifo.sv
// Instruction buffer for the dual-issue stage: exposes the two oldest entries and
// retires 0, 1 or 2 of them per cycle.
module spu_issue_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IW    = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [IW-1:0] push_data,
    input  logic [1:0]    pop,
    output logic [IW-1:0] head,
    output logic [IW-1:0] next,
    output logic [CW-1:0] count
);

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_q;

    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    assign head       = mem_q[rd_ptr_q];
    assign next       = mem_q[rd_ptr_nxt];
    assign count      = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            // Pointers are log2(DEPTH) wide, so the add wraps modulo DEPTH.
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spu_dual_issue.sv
// In-order dual-issue stage: decodes the two oldest buffered words and loads the even
// and odd issue slots, pairing an even head with an independent odd follower.
module spu_dual_issue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IW    = 32,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    output logic          even_valid,
    output logic [IW-1:0] even_instr,
    input  logic          even_ready,
    output logic          odd_valid,
    output logic [IW-1:0] odd_instr,
    input  logic          odd_ready,
    output logic          illegal,
    output logic          stopped,
    output logic [CW-1:0] count
);
    import defines_pkg::*;

    logic [IW-1:0] head;
    logic [IW-1:0] next;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic [1:0]    pop;

    logic          even_valid_q;
    logic [IW-1:0] even_instr_q;
    logic          odd_valid_q;
    logic [IW-1:0] odd_instr_q;
    logic          illegal_q;
    logic          stopped_q;

    // Held low during reset so every output reads 0 while rst is asserted.
    assign in_ready = !rst && (fifo_count < CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;

    spu_issue_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (in_instr),
        .pop       (pop),
        .head      (head),
        .next      (next),
        .count     (fifo_count)
    );

    pipe_e            h0_cls;
    pipe_e            h1_cls;
    logic [REG_W-1:0] h0_rt;
    logic [REG_W-1:0] h1_rt;
    logic [REG_W-1:0] h1_ra;
    logic [REG_W-1:0] h1_rb;
    logic             raw_hazard;
    logic             even_free;
    logic             odd_free;
    logic             can_pair;

    assign h0_cls = pipe_of(head[IW-1 -: OP_W]);
    assign h1_cls = pipe_of(next[IW-1 -: OP_W]);
    assign h0_rt  = head[RT_LSB +: REG_W];
    assign h1_rt  = next[RT_LSB +: REG_W];
    assign h1_ra  = next[RA_LSB +: REG_W];
    assign h1_rb  = next[RB_LSB +: REG_W];

    // Fields are compared whatever the format, so some pairs are blocked conservatively.
    assign raw_hazard = (h1_ra == h0_rt) || (h1_rb == h0_rt) || (h1_rt == h0_rt);
    assign even_free  = !even_valid_q || even_ready;
    assign odd_free   = !odd_valid_q || odd_ready;
    assign can_pair   = (fifo_count >= CW'(2)) && (h1_cls == PIPE_ODD) && odd_free
                        && !raw_hazard;

    logic          load_even;
    logic          load_odd;
    logic [IW-1:0] odd_word;
    logic          illegal_d;
    logic          stop_set;

    always_comb begin
        pop       = 2'd0;
        load_even = 1'b0;
        load_odd  = 1'b0;
        odd_word  = head;
        illegal_d = 1'b0;
        stop_set  = 1'b0;
        if (!flush && !stopped_q && (fifo_count != '0)) begin
            unique case (h0_cls)
                PIPE_ILLEGAL: begin
                    pop       = 2'd1;
                    illegal_d = 1'b1;
                end
                PIPE_CTRL: begin
                    if (even_free && odd_free) begin
                        pop      = 2'd1;
                        stop_set = 1'b1;
                    end
                end
                PIPE_ODD: begin
                    if (odd_free) begin
                        load_odd = 1'b1;
                        pop      = 2'd1;
                    end
                end
                PIPE_EVEN: begin
                    if (even_free) begin
                        load_even = 1'b1;
                        if (can_pair) begin
                            load_odd = 1'b1;
                            odd_word = next;
                            pop      = 2'd2;
                        end else begin
                            pop = 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_valid_q <= 1'b0;
            even_instr_q <= '0;
            odd_valid_q  <= 1'b0;
            odd_instr_q  <= '0;
            illegal_q    <= 1'b0;
            stopped_q    <= 1'b0;
        end else if (flush) begin
            even_valid_q <= 1'b0;
            odd_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            if (load_even) begin
                even_valid_q <= 1'b1;
                even_instr_q <= head;
            end else if (even_ready) begin
                even_valid_q <= 1'b0;
            end
            if (load_odd) begin
                odd_valid_q <= 1'b1;
                odd_instr_q <= odd_word;
            end else if (odd_ready) begin
                odd_valid_q <= 1'b0;
            end
            illegal_q <= illegal_d;
            if (stop_set) begin
                stopped_q <= 1'b1;
            end
        end
    end

    assign even_valid = even_valid_q;
    assign even_instr = even_instr_q;
    assign odd_valid  = odd_valid_q;
    assign odd_instr  = odd_instr_q;
    assign illegal    = illegal_q;
    assign stopped    = stopped_q;
    assign count      = fifo_count;

endmodule

// File: tb/tb_spu_dual_issue.sv
// Scenario bench for spu_dual_issue: per-pipe scoreboards are filled as words are driven
// and drained on each slot handshake; each task adds its own timing checks.
module tb_spu_dual_issue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned IW    = 32;
    localparam int unsigned CW    = 4;

    localparam logic [10:0] OP_ADD  = 11'h0C0;
    localparam logic [10:0] OP_LNOP = 11'h001;
    localparam logic [10:0] OP_NOP  = 11'h201;
    localparam logic [10:0] OP_STOP = 11'h000;
    localparam int CLS_EVEN = 0;
    localparam int CLS_ODD  = 1;
    localparam int CLS_NONE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_instr = '0;
    logic          even_ready = 1'b1;
    logic          odd_ready = 1'b1;
    logic          in_ready;
    logic          even_valid;
    logic [IW-1:0] even_instr;
    logic          odd_valid;
    logic [IW-1:0] odd_instr;
    logic          illegal;
    logic          stopped;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [IW-1:0] even_exp_q[$];
    logic [IW-1:0] odd_exp_q[$];

    spu_dual_issue #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .even_valid (even_valid),
        .even_instr (even_instr),
        .even_ready (even_ready),
        .odd_valid  (odd_valid),
        .odd_instr  (odd_instr),
        .odd_ready  (odd_ready),
        .illegal    (illegal),
        .stopped    (stopped),
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [10:0] op, input logic [6:0] rb,
                                       input logic [6:0] ra, input logic [6:0] rt);
        return {op, rb, ra, rt};
    endfunction

    // One clock: scoreboard handshakes at the falling edge, return 1 time unit after rise.
    task automatic tick(output logic took);
        logic [IW-1:0] want;
        @(negedge clk);
        took = in_valid && in_ready && !flush;
        if (!rst && !flush && even_valid && even_ready) begin
            n_cmp++;
            if (even_exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL even_sb: got %h want no issue", even_instr);
            end else begin
                want = even_exp_q.pop_front();
                if (even_instr !== want) begin
                    n_bad++;
                    $display("FAIL even_sb: got %h want %h", even_instr, want);
                end
            end
        end
        if (!rst && !flush && odd_valid && odd_ready) begin
            n_cmp++;
            if (odd_exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL odd_sb: got %h want no issue", odd_instr);
            end else begin
                want = odd_exp_q.pop_front();
                if (odd_instr !== want) begin
                    n_bad++;
                    $display("FAIL odd_sb: got %h want %h", odd_instr, want);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        logic dummy;
        for (int i = 0; i < n; i++) tick(dummy);
    endtask

    task automatic push_word(input logic [IW-1:0] w, input int cls);
        logic took;
        took = 1'b0;
        if (cls == CLS_EVEN) even_exp_q.push_back(w);
        if (cls == CLS_ODD) odd_exp_q.push_back(w);
        in_valid = 1'b1;
        in_instr = w;
        for (int i = 0; i < 200 && !took; i++) tick(took);
        in_valid = 1'b0;
        if (!took) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: word %h accepted=0 want 1", w);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (even_exp_q.size() != 0 || odd_exp_q.size() != 0); i++)
            step(1);
        step(2);
        n_cmp++;
        if (even_exp_q.size() != 0 || odd_exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending even=%0d odd=%0d want 0/0",
                     even_exp_q.size(), odd_exp_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({in_ready, even_valid, odd_valid, illegal, stopped, count, even_instr, odd_instr}
            !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b ev=%b ov=%b ill=%b stp=%b cnt=%0d want all 0",
                     in_ready, even_valid, odd_valid, illegal, stopped, count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        step(2);
        n_cmp++;
        if (count !== '0 || even_valid !== 1'b0 || odd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: cnt=%0d ev=%b ov=%b want 0/0/0", count, even_valid,
                     odd_valid);
        end
    endtask

    task automatic test_pairing();
        logic [IW-1:0] f, a, l;
        f = mk(OP_ADD, 7'd9, 7'd9, 7'd9);
        a = 32'h1800_8083;
        l = 32'h0020_0000;
        even_ready = 1'b0;
        push_word(f, CLS_EVEN);
        push_word(a, CLS_EVEN);
        push_word(l, CLS_ODD);
        n_cmp++;
        if (count !== CW'(2) || even_valid !== 1'b1 || even_instr !== f) begin
            n_bad++;
            $display("FAIL pair_setup: cnt=%0d ev=%b ei=%h want 2/1/%h", count, even_valid,
                     even_instr, f);
        end
        even_ready = 1'b1;
        step(1);
        n_cmp++;
        if (even_valid !== 1'b1 || odd_valid !== 1'b1 || even_instr !== a || odd_instr !== l
            || count !== '0) begin
            n_bad++;
            $display("FAIL pair_issue: ev=%b ov=%b ei=%h oi=%h cnt=%0d want 1/1/%h/%h/0",
                     even_valid, odd_valid, even_instr, odd_instr, count, a, l);
        end
        drain();
    endtask

    task automatic test_raw_block();
        logic [IW-1:0] f, a, l;
        f = mk(OP_ADD, 7'd9, 7'd9, 7'd9);
        a = 32'h1800_8083;
        l = 32'h0020_0180;
        even_ready = 1'b0;
        push_word(f, CLS_EVEN);
        push_word(a, CLS_EVEN);
        push_word(l, CLS_ODD);
        even_ready = 1'b1;
        step(1);
        n_cmp++;
        if (even_valid !== 1'b1 || even_instr !== a || odd_valid !== 1'b0
            || count !== CW'(1)) begin
            n_bad++;
            $display("FAIL raw_first: ev=%b ei=%h ov=%b cnt=%0d want 1/%h/0/1", even_valid,
                     even_instr, odd_valid, count, a);
        end
        step(1);
        n_cmp++;
        if (odd_valid !== 1'b1 || odd_instr !== l || even_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL raw_second: ov=%b oi=%h ev=%b want 1/%h/0", odd_valid, odd_instr,
                     even_valid, l);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] w[10];
        for (int i = 0; i < 10; i++) w[i] = mk(OP_ADD, 7'(i), 7'(i + 1), 7'(i + 40));
        even_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_word(w[i], CLS_EVEN);
        n_cmp++;
        if (count !== CW'(8) || in_ready !== 1'b0 || even_valid !== 1'b1
            || even_instr !== w[0]) begin
            n_bad++;
            $display("FAIL full: cnt=%0d rdy=%b ev=%b ei=%h want 8/0/1/%h", count, in_ready,
                     even_valid, even_instr, w[0]);
        end
        step(3);
        n_cmp++;
        if (even_instr !== w[0] || count !== CW'(8)) begin
            n_bad++;
            $display("FAIL stall_hold: ei=%h cnt=%0d want %h/8", even_instr, count, w[0]);
        end
        even_ready = 1'b1;
        push_word(w[9], CLS_EVEN);
        drain();
    endtask

    task automatic test_illegal();
        int pulses;
        pulses = 0;
        push_word(32'hFFE0_0000, CLS_NONE);
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (illegal === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || count !== '0) begin
            n_bad++;
            $display("FAIL illegal_pulse: pulses=%0d cnt=%0d want 1/0", pulses, count);
        end
        push_word(mk(OP_NOP, 7'd0, 7'd0, 7'd0), CLS_EVEN);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_word(mk(OP_ADD, 7'd1, 7'd2, 7'(20 + i)), CLS_EVEN);
            else push_word(mk(OP_LNOP, 7'd0, 7'd0, 7'd0), CLS_ODD);
        end
        drain();
        n_cmp++;
        if (count !== '0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: cnt=%0d ill=%b want 0/0", count, illegal);
        end
    endtask

    task automatic test_stop();
        push_word(mk(OP_NOP, 7'd0, 7'd0, 7'd1), CLS_EVEN);
        push_word(mk(OP_STOP, 7'd0, 7'd0, 7'd0), CLS_NONE);
        push_word(mk(OP_NOP, 7'd1, 7'd2, 7'd3), CLS_NONE);
        step(3);
        n_cmp++;
        if (stopped !== 1'b1 || count !== CW'(1) || even_valid !== 1'b0
            || odd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_hold: stp=%b cnt=%0d ev=%b ov=%b want 1/1/0/0", stopped, count,
                     even_valid, odd_valid);
        end
        drain();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        n_cmp++;
        if (count !== '0 || stopped !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_flush: cnt=%0d stp=%b want 0/1", count, stopped);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (stopped !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_rst: stp=%b cnt=%0d rdy=%b want 0/0/1", stopped, count,
                     in_ready);
        end
    endtask

    task automatic test_async_reset();
        even_ready = 1'b0;
        push_word(mk(OP_ADD, 7'd9, 7'd9, 7'd9), CLS_EVEN);
        push_word(32'h1800_8083, CLS_EVEN);
        push_word(32'h0020_0000, CLS_ODD);
        n_cmp++;
        if (even_valid !== 1'b1 || count !== CW'(2)) begin
            n_bad++;
            $display("FAIL areset_setup: ev=%b cnt=%0d want 1/2", even_valid, count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, even_valid, odd_valid, illegal, stopped, count, even_instr, odd_instr}
            !== '0) begin
            n_bad++;
            $display("FAIL areset_outputs: rdy=%b ev=%b ov=%b cnt=%0d ei=%h want all 0",
                     in_ready, even_valid, odd_valid, count, even_instr);
        end
        even_exp_q.delete();
        odd_exp_q.delete();
        step(1);
        rst = 1'b0;
        even_ready = 1'b1;
        push_word(mk(OP_NOP, 7'd0, 7'd0, 7'd5), CLS_EVEN);
        drain();
    endtask

    initial begin
        test_reset();
        test_pairing();
        test_raw_block();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_stop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
